// File: rtl/seq_onehot_decoder_pkg.sv
// Shared types for seq_onehot_decoder: FSM state encoding and mode constants.
package seq_dec_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIRECT = 2'd1,
    SCAN   = 2'd2
  } state_e;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/seq_onehot_decoder_onehot_dec.sv
// Combinational SEL_W -> OUT_N one-hot decoder with an in-range flag.
module onehot_dec #(
  parameter int SEL_W = 3,
  parameter int OUT_N = 8
) (
  input  logic [SEL_W-1:0] sel,
  output logic [OUT_N-1:0] onehot,
  output logic             in_range
);

  always_comb begin
    onehot = '0;
    for (int i = 0; i < OUT_N; i++) begin
      onehot[i] = (sel == SEL_W'(i));
    end
  end

  // Zero-extend before comparing so OUT_N == 2**SEL_W is handled correctly.
  assign in_range = ({{(32-SEL_W){1'b0}}, sel} < 32'(OUT_N));

endmodule

// File: rtl/seq_onehot_decoder.sv
// Registered parametrised one-hot decoder with DIRECT and SCAN modes.
// Optional macro SEQ_ONEHOT_DECODER_ACTIVE_LOW_EN drives the out port inverted.
module seq_onehot_decoder
  import seq_dec_pkg::*;
#(
  parameter int SEL_W = 3,
  parameter int OUT_N = 8,
  parameter int DWELL = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic [SEL_W-1:0] sel,
  output logic [OUT_N-1:0] out,
  output logic [SEL_W-1:0] idx,
  output logic             valid,
  output logic             err
);

  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;

  state_e             state_q, state_d;
  logic [OUT_N-1:0]   out_q, out_d;
  logic [SEL_W-1:0]   idx_q, idx_d;
  logic               valid_q, valid_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [OUT_N-1:0]   dec_onehot;
  logic               dec_in_range;

  onehot_dec #(
    .SEL_W (SEL_W),
    .OUT_N (OUT_N)
  ) u_dec (
    .sel      (sel),
    .onehot   (dec_onehot),
    .in_range (dec_in_range)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      out_q   <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = IDLE;
    if (en) begin
      state_d = (mode == MODE_SCAN) ? SCAN : DIRECT;
    end
  end

  // Outputs are computed for the state being entered, so they appear one edge after the inputs.
  always_comb begin
    out_d   = '0;
    idx_d   = idx_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    cnt_d   = '0;
    case (state_d)
      DIRECT: begin
        if (dec_in_range) begin
          out_d   = dec_onehot;
          idx_d   = sel;
          valid_d = 1'b1;
        end else begin
          err_d   = 1'b1;
        end
      end
      SCAN: begin
        valid_d = 1'b1;
        if (state_q != SCAN) begin
          idx_d = '0;
          cnt_d = '0;
        end else if (cnt_q == CNT_W'(DWELL - 1)) begin
          cnt_d = '0;
          idx_d = (idx_q == SEL_W'(OUT_N - 1)) ? '0 : idx_q + SEL_W'(1);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        out_d = OUT_N'(1) << idx_d;
      end
      default: begin
        cnt_d = '0;
      end
    endcase
  end

`ifdef SEQ_ONEHOT_DECODER_ACTIVE_LOW_EN
  assign out = ~out_q;
`else
  assign out = out_q;
`endif
  assign idx   = idx_q;
  assign valid = valid_q;
  assign err   = err_q;

endmodule

// File: doc/seq_onehot_decoder.md
# seq_onehot_decoder

Registered, parametrised binary-to-one-hot decoder. It generalises the fixed 3-to-8 combinational decoder in two ways: select width and output count are parameters, and a built-in scan mode walks the active output through every position with a programmable dwell time. It sits between control logic and one-hot consumers such as display digit enables, bank selects and chip selects. All outputs are registered.

## Interface
Parameters:
- `SEL_W`, default 3: select width in bits.
- `OUT_N`, default 8: number of one-hot outputs. Legal range is 2 ≤ OUT_N ≤ 2**SEL_W.
- `DWELL`, default 4: number of cycles each output stays active in scan mode. Must be ≥ 1.

Ports:
- `clk`, in, 1: the single clock. Everything is on the rising edge.
- `rst`, in, 1: reset. Synchronous and active-high.
- `en`, in, 1: decoder enable.
- `mode`, in, 1: 0 = DIRECT, 1 = SCAN.
- `sel`, in, SEL_W: select value, used in DIRECT mode.
- `out`, out, OUT_N: registered one-hot output.
- `idx`, out, SEL_W: binary index of the active output.
- `valid`, out, 1: high when `out` holds exactly one active bit.
- `err`, out, 1: out-of-range select flag, for DIRECT mode.

## Operation
- FSM states are IDLE, DIRECT and SCAN. The next state is evaluated every cycle:
  - `en`=0 → IDLE
  - `en`=1, `mode`=0 → DIRECT
  - `en`=1, `mode`=1 → SCAN
- **IDLE**
  - `out`=0, `valid`=0, `err`=0.
  - `idx` holds its last value.
  - Dwell counter cleared.
- **DIRECT**
  - `sel` is sampled every cycle.
  - If `sel` < OUT_N: `out` = 1<<`sel`, `idx`=`sel`, `valid`=1, `err`=0.
  - If `sel` ≥ OUT_N: `out`=0, `valid`=0, `err`=1, `idx` holds.
- **SCAN**
  - On entry from any other state: `idx`=0, `out`=1, dwell counter=0, `valid`=1.
  - The dwell counter counts 0..DWELL-1. When it reaches DWELL-1, `idx` increments and the counter returns to 0.
  - `idx` wraps from OUT_N-1 to 0. It never visits values ≥ OUT_N.
  - `sel` is ignored. `err`=0.
- Mode change while `en`=1 takes effect on the next edge.
  - DIRECT→SCAN always restarts the scan at index 0.
  - SCAN→DIRECT decodes the current `sel`.
- Dropping `en` mid-scan and raising it again restarts the scan at index 0; there is no resume.
- Outputs obey `out` = (`valid` ? 1<<`idx` : 0) at all times. This is a verification invariant.

## Timing
- Latency is 1 cycle: inputs sampled at edge N appear on the outputs after edge N.
- Reset (`rst`=1 at an edge), taking priority over everything:
  - state=IDLE
  - `out`=0, `idx`=0, `valid`=0, `err`=0
  - dwell counter=0
- Reset asserted mid-scan clears the scan immediately. The first edge with `rst`=0, `en`=1, `mode`=1 produces `idx`=0.
- In SCAN each index is held for exactly DWELL cycles. A full scan period is OUT_N×DWELL cycles.
- With DWELL=1, `idx` advances every cycle.

## Configuration
- Macro: `SEQ_ONEHOT_DECODER_ACTIVE_LOW_EN`.
- When defined: the `out` port is driven inverted.
  - Active bit = 0, all others 1.
  - IDLE, reset and error conditions drive all ones.
  - `valid`, `idx` and `err` are unchanged.
- When undefined: `out` is active-high as described above.

## Structure
- Shared package `seq_dec_pkg` holds:
  - the state enum (IDLE, DIRECT, SCAN)
  - the mode constants MODE_DIRECT=0 and MODE_SCAN=1
- One sub-module, `onehot_dec`: a purely combinational, parametrised SEL_W→OUT_N decoder that also produces the in-range flag. The top level registers its result.
- The FSM, dwell counter and index counter live in the top level.

## Test plan
1. Reset then DIRECT with defaults. Apply `rst`=1 for 2 cycles, release, then `en`=1, `mode`=0, `sel`=5. Required: after reset `out`=8'h00, `valid`=0. One cycle after the select, `out`=8'h20, `idx`=5, `valid`=1.
2. Out-of-range select with OUT_N=6. Apply `sel`=6, then `sel`=7. Required: `out`=0, `err`=1, `valid`=0, `idx` holds its previous value. Then apply `sel`=2. Required: `out`=6'b000100, `err`=0.
3. Scan timing with DWELL=4, OUT_N=8. Hold `en`=1, `mode`=1 for 40 cycles. Required: `idx` sequence 0,1,…,7,0,1 with each value held exactly 4 cycles, and `out`=1<<`idx` throughout.
4. Restart behaviour. Go DIRECT→SCAN with `sel`=3; later drop `en` at `idx`=5 for 1 cycle and re-raise it. Required: the scan starts at `idx`=0 both times, and `out`=0 during the `en`=0 cycle.
5. Reset mid-scan at `idx`=4. Required: the next cycle shows `out`=0, `idx`=0. After release, the scan restarts at 0.
6. Configuration macro. Rerun scenario 1 with `SEQ_ONEHOT_DECODER_ACTIVE_LOW_EN` defined. Required: `out`=8'hFF during reset and `out`=8'hDF for `sel`=5.
